// File: rtl/inst_buffer_pkg.sv
// Shared types and default sizing for the instruction fetch buffer.
// Sizing defaults here are what inst_fetch_buffer falls back to.
package inst_buffer_pkg;

    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_DEPTH      = 4;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_buffer_ram.sv
// Entry storage for the fetch buffer: one write port, one async read port.
// Contents are never cleared; validity is tracked by the owner's count.
module inst_buffer_ram
    import inst_buffer_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  entry_t                   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output entry_t                   rd_data
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch-to-decode instruction FIFO with flush; optional empty-bypass path
// enabled by defining INST_FETCH_BUFFER_BYPASS_EN.
module inst_fetch_buffer
    import inst_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [ADDR_WIDTH-1:0]    in_pc,
    input  logic [INST_WIDTH-1:0]    in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [ADDR_WIDTH-1:0]    out_pc,
    output logic [INST_WIDTH-1:0]    out_inst,
    input  logic                     out_ready,
    output logic                     buffer_stall,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    entry_t wr_data;
    entry_t head;

    logic push;
    logic pop;
    logic show_in;
    logic bypass_take;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_FULL);
    assign buffer_stall = full;
    assign in_ready     = !full;
    assign count        = count_q;

`ifdef INST_FETCH_BUFFER_BYPASS_EN
    // While empty, the incoming word is presented straight to decode;
    // if decode takes it now it never needs a slot.
    assign show_in     = empty && in_valid && !flush;
    assign bypass_take = show_in && out_ready;
`else
    assign show_in     = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign push = in_valid && in_ready && !bypass_take;
    assign pop  = !empty && out_ready;

    assign out_valid = !empty || show_in;
    assign out_pc    = show_in ? in_pc   : head.pc;
    assign out_inst  = show_in ? in_inst : head.inst;

    assign wr_data.pc   = in_pc;
    assign wr_data.inst = in_inst;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Flush and reset squash the write as well as the pointer update.
    inst_buffer_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push && reset && !flush),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed self-checking bench for inst_fetch_buffer (default sizing).
// Bypass expectations follow INST_FETCH_BUFFER_BYPASS_EN when defined.
module tb_inst_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic        buffer_stall;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    inst_fetch_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_ready    (out_ready),
        .buffer_stall (buffer_stall),
        .empty        (empty),
        .full         (full),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
    endtask

    task automatic push_pc(input logic [63:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = pc[31:0] ^ 32'hA5A5_0000;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_idle_state(input string name);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 ||
            buffer_stall !== 1'b0 || in_ready !== 1'b1 ||
            out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: cnt=%0d emp=%b full=%b stall=%b rdy=%b ov=%b, need 0 1 0 0 1 0",
                     name, count, empty, full, buffer_stall, in_ready, out_valid);
        end
    endtask

    task automatic drain_expect(input logic [63:0] pc, input string name);
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== pc ||
            out_inst !== (pc[31:0] ^ 32'hA5A5_0000)) begin
            errors++;
            $display("FAIL %s: ov=%b pc=%h inst=%h, need ov=1 pc=%h", name,
                     out_valid, out_pc, out_inst, pc);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        check_idle_state("reset");
        reset = 1'b1;
        tick();
        check_idle_state("reset_release");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push_pc(64'(4 * i));
        end
        checks++;
        if (full !== 1'b1 || buffer_stall !== 1'b1 || in_ready !== 1'b0 ||
            count !== 3'd4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill: full=%b stall=%b rdy=%b cnt=%0d ov=%b, need 1 1 0 4 1",
                     full, buffer_stall, in_ready, count, out_valid);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drain_expect(64'(4 * i), "drain_order");
        end
        check_idle_state("drain_empty");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_idle_state("pop_when_empty");
    endtask

    task automatic test_full_refuse();
        for (int i = 0; i < 4; i++) begin
            push_pc(64'h500 + 64'(4 * i));
        end
        in_valid  = 1'b1;
        in_pc     = 64'h5F0;
        in_inst   = 32'h1234_5678;
        out_ready = 1'b1;
        tick();
        idle();
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL full_push_refused: count=%0d, need 3", count);
        end
        for (int i = 1; i < 4; i++) begin
            drain_expect(64'h500 + 64'(4 * i), "full_refuse_order");
        end
        check_idle_state("full_refuse_empty");
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_pc;
        push_pc(64'h300);
        push_pc(64'h304);
        for (int i = 0; i < 10; i++) begin
            exp_pc    = 64'h300 + 64'(4 * i);
            in_valid  = 1'b1;
            in_pc     = 64'h308 + 64'(4 * i);
            in_inst   = in_pc[31:0] ^ 32'hA5A5_0000;
            out_ready = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
                errors++;
                $display("FAIL b2b_order[%0d]: ov=%b pc=%h, need ov=1 pc=%h",
                         i, out_valid, out_pc, exp_pc);
            end
            tick();
            checks++;
            if (count !== 3'd2) begin
                errors++;
                $display("FAIL b2b_count[%0d]: count=%0d, need 2", i, count);
            end
        end
        idle();
        drain_expect(64'h328, "b2b_tail0");
        drain_expect(64'h32C, "b2b_tail1");
        check_idle_state("b2b_empty");
    endtask

    task automatic test_flush();
        push_pc(64'h10);
        push_pc(64'h14);
        push_pc(64'h18);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 64'h100;
        in_inst   = 32'hDEAD_0100;
        out_ready = 1'b1;
        tick();
        idle();
        check_idle_state("flush");
        push_pc(64'h200);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h200 || count !== 3'd1) begin
            errors++;
            $display("FAIL flush_next_push: ov=%b pc=%h cnt=%0d, need 1 200 1",
                     out_valid, out_pc, count);
        end
        drain_expect(64'h200, "flush_drain");
        check_idle_state("flush_empty");
    endtask

    task automatic test_reset_mid();
        push_pc(64'h60);
        push_pc(64'h64);
        push_pc(64'h68);
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h6C;
        out_ready = 1'b1;
        tick();
        idle();
        check_idle_state("reset_mid");
        reset = 1'b1;
        push_pc(64'h700);
        checks++;
        if (count !== 3'd1 || out_pc !== 64'h700) begin
            errors++;
            $display("FAIL reset_mid_push: cnt=%0d pc=%h, need 1 700",
                     count, out_pc);
        end
        drain_expect(64'h700, "reset_mid_drain");
    endtask

    task automatic test_bypass();
        in_valid  = 1'b1;
        in_pc     = 64'h40;
        in_inst   = 32'hA5A5_0040;
        out_ready = 1'b1;
        #1;
        checks++;
`ifdef INST_FETCH_BUFFER_BYPASS_EN
        if (out_valid !== 1'b1 || out_pc !== 64'h40) begin
            errors++;
            $display("FAIL bypass_same_cycle: ov=%b pc=%h, need 1 40",
                     out_valid, out_pc);
        end
        tick();
        idle();
        check_idle_state("bypass_no_write");
`else
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_same_cycle: ov=%b, need 0", out_valid);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h40 || count !== 3'd1) begin
            errors++;
            $display("FAIL nobypass_next: ov=%b pc=%h cnt=%0d, need 1 40 1",
                     out_valid, out_pc, count);
        end
        drain_expect(64'h40, "nobypass_drain");
        check_idle_state("nobypass_empty");
`endif
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_full_refuse();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, PC width.
REQ-002 Parameter INST_WIDTH, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset: one clock, reset synchronous and active-low.
REQ-006 Port flush  input  1  discard all entries (branch/jump/override redirect).
REQ-007 Port in_valid  input  1  fetch stage presents pc/instruction.
REQ-008 Port in_pc  input  ADDR_WIDTH  PC of fetched word.
REQ-009 Port in_inst  input  INST_WIDTH  fetched instruction word.
REQ-010 Port in_ready  output  1  buffer accepts push this cycle.
REQ-011 Port out_valid  output  1  head entry valid to decode.
REQ-012 Port out_pc  output  ADDR_WIDTH  head PC.
REQ-013 Port out_inst  output  INST_WIDTH  head instruction.
REQ-014 Port out_ready  input  1  decode consumes head this cycle.
REQ-015 Port buffer_stall  output  1  equals full; drives fetch stall.
REQ-016 Port empty  output  1  count == 0.
REQ-017 Port full  output  1  count == DEPTH.
REQ-018 Port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-020 in_ready = !full; a push is refused when full, even with a same-cycle pop.
REQ-021 out_valid = !empty; out_pc/out_inst are the head entry, registered, with no combinational path from in_* (bypass excepted, REQ-030).
REQ-022 Push-to-out_valid latency is 1 cycle when empty.
REQ-023 Strict FIFO order; read/write pointers have log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 Simultaneous push and pop with count unchanged and 0<count<DEPTH: both pointers advance.
REQ-025 Pop with empty has no effect; push with full has no effect.
REQ-026 Flush has priority: the next cycle has count=0 and both pointers=0; a same-cycle push or pop is discarded.
REQ-027 out_pc/out_inst hold their last value when empty; they are don't-care and must not be checked.

Reset
REQ-028 When reset=0 at a clock edge: count=0, pointers=0, out_valid=0, empty=1, full=0, buffer_stall=0, in_ready=1; storage is not cleared.
REQ-029 Reset mid-operation discards all entries, identical to flush; a same-cycle push is ignored.

Configuration
REQ-030 Macro INST_FETCH_BUFFER_BYPASS_EN defined: when empty && in_valid && out_ready && !flush, in_pc/in_inst pass combinationally to out_*, out_valid=1, and nothing is written. When empty && in_valid && !out_ready, out_valid=1 combinationally and the word is written.
REQ-031 Macro undefined: no combinational in-to-out path; REQ-022 applies.

Structure
REQ-032 Package inst_buffer_pkg holds the typedef fetch_entry_t {pc, inst} and the default constants for ADDR_WIDTH, INST_WIDTH and DEPTH.
REQ-033 Storage lives in sub-module inst_buffer_ram (DEPTH x fetch_entry_t, 1 write, 1 async read); pointers and count live in the top module.

Verification
REQ-034 Reset, then push pc 0x0,0x4,0x8,0xC (out_ready=0) -> full=1, buffer_stall=1, in_ready=0, count=4.
REQ-035 From full, pop 4 cycles -> out_pc 0x0,0x4,0x8,0xC in order; then empty=1, out_valid=0.
REQ-036 count=2, push and pop the same cycle for 10 cycles -> count stays 2, order preserved, pointers wrap.
REQ-037 count=3, flush with in_valid=1 pc=0x100 -> next cycle count=0, 0x100 absent; following push 0x200 -> out_pc=0x200.
REQ-038 Reset=0 asserted with count=3 and push/pop active -> next cycle all outputs at reset values.
REQ-039 BYPASS_EN: empty, in_valid, out_ready, pc=0x40 -> same-cycle out_valid=1, out_pc=0x40, count remains 0. Macro undefined: out_valid is 0 that cycle and 1 the next.
